// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath/memory side.
// The master modport is the FSM. The slave modport is the datapath together with the memory.
interface multicycle_ctrl_fsm_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       branch;
    logic       instr_done;
    logic       illegal_instr;
    logic       bus_error;
    logic [3:0] state_o;

    modport master (
        input  opcode, mem_ready,
        output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, branch,
               instr_done, illegal_instr, bus_error, state_o
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, branch,
               instr_done, illegal_instr, bus_error, state_o
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I-subset control FSM (R, LW, SW, BEQ, LUI, ADDI).
// It drives the datapath selects from the IR opcode and guards memory waits with a timeout watchdog.
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    multicycle_ctrl_fsm_if.master bus
);
    localparam int CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BEQ    = 4'd9,
        S_LUI    = 4'd10
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          wait_st_s, timeout_s;
    logic          pc_write_s, ir_write_s, adr_src_s, mem_read_s, mem_write_s, reg_write_s;
    logic [1:0]    alu_src_a_s, alu_src_b_s, alu_op_s, result_src_s;
    logic          branch_s, instr_done_s, illegal_instr_s, bus_error_s;

    // State and watchdog counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= S_FETCH;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state and Moore outputs; fetch/memory completions are gated by mem_ready
    always_comb begin
        state_s         = state_r;
        pc_write_s      = 1'b0;
        ir_write_s      = 1'b0;
        adr_src_s       = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        reg_write_s     = 1'b0;
        alu_src_a_s     = 2'b00;
        alu_src_b_s     = 2'b00;
        alu_op_s        = 2'b00;
        result_src_s    = 2'b00;
        branch_s        = 1'b0;
        instr_done_s    = 1'b0;
        illegal_instr_s = 1'b0;
        bus_error_s     = 1'b0;
        wait_st_s       = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
        timeout_s       = wait_st_s && !bus.mem_ready && (cnt_r == CNT_LIMIT);
        case (state_r)
            S_FETCH: begin
                mem_read_s   = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                if (bus.mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_s    = S_DECODE;
                end else if (timeout_s) begin
                    bus_error_s = 1'b1;
                    state_s     = S_FETCH;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (bus.opcode)
                    OP_R:    state_s = S_EXECR;
                    OP_LW:   state_s = S_MEMADR;
                    OP_SW:   state_s = S_MEMADR;
                    OP_BEQ:  state_s = S_BEQ;
                    OP_ADDI: state_s = S_EXECI;
                    OP_LUI:  state_s = S_LUI;
                    default: begin
                        illegal_instr_s = 1'b1;
                        state_s         = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (bus.opcode == OP_LW) begin
                    state_s = S_MEMRD;
                end else if (bus.opcode == OP_SW) begin
                    state_s = S_MEMWR;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                adr_src_s  = 1'b1;
                if (bus.mem_ready) begin
                    state_s = S_MEMWB;
                end else if (timeout_s) begin
                    bus_error_s = 1'b1;
                    state_s     = S_FETCH;
                end else begin
                    state_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                result_src_s = 2'b01;
                instr_done_s = 1'b1;
                state_s      = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                adr_src_s   = 1'b1;
                if (bus.mem_ready) begin
                    instr_done_s = 1'b1;
                    state_s      = S_FETCH;
                end else if (timeout_s) begin
                    bus_error_s = 1'b1;
                    state_s     = S_FETCH;
                end else begin
                    state_s = S_MEMWR;
                end
            end
            S_EXECR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b00;
                alu_op_s    = 2'b10;
                state_s     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = 2'b10;
                state_s     = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = 2'b11;
                state_s     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                result_src_s = 2'b00;
                instr_done_s = 1'b1;
                state_s      = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b00;
                alu_op_s     = 2'b01;
                result_src_s = 2'b00;
                branch_s     = 1'b1;
                instr_done_s = 1'b1;
                state_s      = S_FETCH;
            end
            default: begin
                state_s = S_FETCH;
            end
        endcase
    end

    // Watchdog: cleared on any state change or abort, counts unanswered wait cycles, saturates via abort
    always_comb begin
        cnt_s = cnt_r;
        if (timeout_s) begin
            cnt_s = {CW{1'b0}};
        end else if (state_s != state_r) begin
            cnt_s = {CW{1'b0}};
        end else if (wait_st_s && !bus.mem_ready) begin
            cnt_s = cnt_r + CW'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    assign bus.pc_write      = reset_n ? pc_write_s      : 1'b0;
    assign bus.ir_write      = reset_n ? ir_write_s      : 1'b0;
    assign bus.adr_src       = reset_n ? adr_src_s       : 1'b0;
    assign bus.mem_read      = reset_n ? mem_read_s      : 1'b0;
    assign bus.mem_write     = reset_n ? mem_write_s     : 1'b0;
    assign bus.reg_write     = reset_n ? reg_write_s     : 1'b0;
    assign bus.alu_src_a     = reset_n ? alu_src_a_s     : 2'b00;
    assign bus.alu_src_b     = reset_n ? alu_src_b_s     : 2'b00;
    assign bus.alu_op        = reset_n ? alu_op_s        : 2'b00;
    assign bus.result_src    = reset_n ? result_src_s    : 2'b00;
    assign bus.branch        = reset_n ? branch_s        : 1'b0;
    assign bus.instr_done    = reset_n ? instr_done_s    : 1'b0;
    assign bus.illegal_instr = reset_n ? illegal_instr_s : 1'b0;
    assign bus.bus_error     = reset_n ? bus_error_s     : 1'b0;
    assign bus.state_o       = reset_n ? state_r         : 4'd0;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: each instruction attempt's expected outcome is computed
// from its opcode class and memory latencies, then compared when the DUT pulses done/illegal/bus_error.
module tb_multicycle_ctrl_fsm;
    localparam int T = 4;
    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_ADDI = 3, C_LUI = 4, C_BEQ = 5, C_ILL = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    multicycle_ctrl_fsm_if bus();

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(T)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;    // 0 retired, 1 illegal, 2 bus error
        int cycles;
        int trace;   // distinct state codes visited, one nibble each
        int rw, br, mw, mr, iw, mdr, adr, alu;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] op_q[$];
    int         lat_q[$];
    logic [6:0] opc_tab [0:5];
    int         tests = 0;
    int         fails = 0;
    bit         run = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: latency is a fetch phase (lf wait cycles) plus fixed steps per class.
    function automatic exp_t model(input int cls, input int lf, input int lm);
        exp_t e;
        int   base;
        e = '{default: 0};
        if (lf >= T) begin
            e.kind = 2; e.cycles = T; e.trace = 'h0; e.mr = T;
            return e;
        end
        base = lf + 1;
        e.mr = lf + 1;
        e.iw = 1;
        case (cls)
            C_LW: begin
                if (lm >= T) begin
                    e.kind = 2; e.cycles = base + 2 + T; e.trace = 'h0123; e.mr += T; e.adr = T;
                end else begin
                    e.cycles = base + 2 + lm + 2; e.trace = 'h01234; e.mr += lm + 1;
                    e.adr = lm + 1; e.rw = 1; e.mdr = 1;
                end
            end
            C_SW: begin
                if (lm >= T) begin
                    e.kind = 2; e.cycles = base + 2 + T; e.trace = 'h0125; e.mw = T; e.adr = T;
                end else begin
                    e.cycles = base + 2 + lm + 1; e.trace = 'h0125; e.mw = lm + 1; e.adr = lm + 1;
                end
            end
            C_R:    begin e.cycles = base + 3; e.trace = 'h0168; e.rw = 1; e.alu = 2; end
            C_ADDI: begin e.cycles = base + 3; e.trace = 'h0178; e.rw = 1; e.alu = 2; end
            C_LUI:  begin e.cycles = base + 3; e.trace = 'h01A8; e.rw = 1; e.alu = 3; end
            C_BEQ:  begin e.cycles = base + 2; e.trace = 'h019;  e.br = 1; e.alu = 1; end
            default: begin e.kind = 1; e.cycles = base + 1; e.trace = 'h01; end
        endcase
        return e;
    endfunction

    task automatic issue(input int cls, input logic [6:0] opc, input int lf, input int lm);
        op_q.push_back(opc);
        lat_q.push_back(lf);
        if (lf < T && (cls == C_LW || cls == C_SW)) lat_q.push_back(lm);
        exp_q.push_back(model(cls, lf, lm));
    endtask

    function automatic logic [6:0] pick_opc(input int cls);
        logic [6:0] o;
        if (cls < C_ILL) return opc_tab[cls];
        o = 7'b1111111;
        while (o == opc_tab[0] || o == opc_tab[1] || o == opc_tab[2] ||
               o == opc_tab[3] || o == opc_tab[4] || o == opc_tab[5])
            o = 7'($urandom_range(0, 127));
        return o;
    endfunction

    // Memory responder and opcode driver: answers each request after its planned latency
    int  r_k = 0, r_lat = 0;
    bit  r_req = 1'b0, r_new = 1'b1;
    always begin
        @(negedge clk);
        #1;
        if (run) begin
            if (r_new) begin
                if (op_q.size() > 0) bus.opcode = op_q.pop_front();
                r_new = 1'b0;
            end
            if (bus.mem_read || bus.mem_write) begin
                if (!r_req) begin
                    r_req = 1'b1;
                    r_k   = 0;
                    r_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                end
                bus.mem_ready = (r_k == r_lat);
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (r_req) begin
                if (bus.mem_ready || r_k == T - 1) r_req = 1'b0;
                else r_k++;
            end
            if (bus.instr_done || bus.illegal_instr || bus.bus_error) r_new = 1'b1;
        end
    end

    // Monitor: accumulates observed behaviour per attempt and checks it at each terminating pulse
    int   m_cyc = 0, m_trace = 0, m_last = -1;
    int   m_rw = 0, m_br = 0, m_mw = 0, m_mr = 0, m_iw = 0, m_pw = 0, m_mdr = 0, m_adr = 0, m_alu = 0;
    int   m_nev, m_kind;
    exp_t m_e;
    always begin
        @(negedge clk);
        #3;
        if (run) begin
            m_cyc++;
            if (int'(bus.state_o) != m_last) begin
                m_trace = (m_trace << 4) | int'(bus.state_o);
                m_last  = int'(bus.state_o);
            end
            m_rw  += int'(bus.reg_write);
            m_br  += int'(bus.branch);
            m_mw  += int'(bus.mem_write);
            m_mr  += int'(bus.mem_read);
            m_iw  += int'(bus.ir_write);
            m_pw  += int'(bus.pc_write);
            m_adr += int'(bus.adr_src);
            if (bus.result_src == 2'b01) m_mdr++;
            if (bus.alu_op != 2'b00) m_alu = int'(bus.alu_op);
            m_nev = int'(bus.instr_done) + int'(bus.illegal_instr) + int'(bus.bus_error);
            if (m_nev != 0) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got pulse with %0d expected attempts pending", 0);
                end else begin
                    m_e    = exp_q.pop_front();
                    m_kind = bus.instr_done ? 0 : (bus.illegal_instr ? 1 : 2);
                    chk("pulse_count", m_nev, 1);
                    chk("event_kind", m_kind, m_e.kind);
                    chk("cycles", m_cyc, m_e.cycles);
                    chk("state_trace", m_trace, m_e.trace);
                    chk("reg_write", m_rw, m_e.rw);
                    chk("branch", m_br, m_e.br);
                    chk("mem_write", m_mw, m_e.mw);
                    chk("mem_read", m_mr, m_e.mr);
                    chk("ir_write", m_iw, m_e.iw);
                    chk("pc_write", m_pw, m_e.iw);
                    chk("result_mdr", m_mdr, m_e.mdr);
                    chk("adr_src", m_adr, m_e.adr);
                    chk("exec_alu_op", m_alu, m_e.alu);
                end
                m_cyc = 0; m_trace = 0; m_last = -1;
                m_rw = 0; m_br = 0; m_mw = 0; m_mr = 0; m_iw = 0; m_pw = 0; m_mdr = 0; m_adr = 0; m_alu = 0;
            end
        end
    end

    // Stimulus: directed scenarios first, then random attempts; then reset and drain
    initial begin
        int guard;
        int cls, lf, lm;
        bus.opcode    = 7'd0;
        bus.mem_ready = 1'b1;
        opc_tab[0] = 7'b0000011;
        opc_tab[1] = 7'b0100011;
        opc_tab[2] = 7'b0110011;
        opc_tab[3] = 7'b0010011;
        opc_tab[4] = 7'b0110111;
        opc_tab[5] = 7'b1100011;

        issue(C_LW,   opc_tab[C_LW],   0, 0);
        issue(C_SW,   opc_tab[C_SW],   0, 3);
        issue(C_ADDI, opc_tab[C_ADDI], 0, 0);
        issue(C_R,    opc_tab[C_R],    0, 0);
        issue(C_LUI,  opc_tab[C_LUI],  0, 0);
        issue(C_BEQ,  opc_tab[C_BEQ],  0, 0);
        issue(C_ILL,  7'b1111111,      0, 0);
        issue(C_LW,   opc_tab[C_LW],   0, T);
        issue(C_LW,   opc_tab[C_LW],   0, T - 1);
        issue(C_SW,   opc_tab[C_SW],   1, T);
        issue(C_R,    opc_tab[C_R],    T, 0);
        issue(C_R,    opc_tab[C_R],    T - 1, 0);
        for (int i = 0; i < 80; i++) begin
            cls = $urandom_range(0, 6);
            lf  = ($urandom_range(0, 5) == 0) ? T : $urandom_range(0, T - 1);
            lm  = $urandom_range(0, T);
            issue(cls, pick_opc(cls), lf, lm);
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #3;
            chk("reset_outputs_zero",
                int'({bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_read, bus.mem_write,
                      bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src,
                      bus.branch, bus.instr_done, bus.illegal_instr, bus.bus_error, bus.state_o}), 0);
        end

        @(negedge clk);
        reset_n = 1'b1;
        run     = 1'b1;
        #3;
        chk("post_reset_state", int'(bus.state_o), 0);
        chk("post_reset_mem_read", int'(bus.mem_read), 1);
        chk("post_reset_ir_write", int'(bus.ir_write), 1);
        chk("post_reset_pc_write", int'(bus.pc_write), 1);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        reset_n = 1'b0;
        run     = 1'b0;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending attempts expected 0", exp_q.size());
        end
        @(negedge clk);
        #3;
        chk("final_reset_state", int'(bus.state_o), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
